// File: rtl/uart_fifo_core.sv
// Purpose: full-duplex UART (DATA_BITS, PARITY, STOP_BITS configurable) with an RX first-word-fall-through FIFO.
// Latency: tx_pin drops 1 clk after tx_start is sampled; a received byte is visible 1 clk after its stop-bit sample.
// Backpressure: tx_start is ignored while tx_busy; an RX byte arriving with the FIFO full and no pop is dropped (sticky rx_overrun).
// Ports: clk/rst (synchronous, active-high); rx_pin/tx_pin serial lines (idle high);
//        tx_byte/tx_start/tx_busy transmit side; rx_byte/rx_valid/rx_rd/rx_count FIFO head and occupancy;
//        rx_busy, rx_frame_err/rx_parity_err (1-clk pulses), rx_overrun (sticky) and err_clear status.
module uart_fifo_core #(
    parameter int CLOCK         = 100000000,
    parameter int BAUD          = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx_pin,
    output logic                             tx_pin,
    input  logic [DATA_BITS-1:0]             tx_byte,
    input  logic                             tx_start,
    output logic                             tx_busy,
    output logic [DATA_BITS-1:0]             rx_byte,
    output logic                             rx_valid,
    input  logic                             rx_rd,
    output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count,
    output logic                             rx_busy,
    output logic                             rx_frame_err,
    output logic                             rx_parity_err,
    output logic                             rx_overrun,
    input  logic                             err_clear
);
    localparam int DIV  = CLOCK / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int AW   = $clog2(RX_FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(RX_FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t               tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_pin   <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_start) begin
                        tx_shift <= tx_byte;
                        tx_par   <= (PARITY == 1) ? ~^tx_byte : ^tx_byte;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_pin   <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt   <= '0;
                        tx_pin   <= tx_shift[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt <= '0;
                        if (tx_bit == LAST_BIT) begin
                            tx_bit <= '0;
                            if (PARITY != 0) begin
                                tx_pin   <= tx_par;
                                tx_state <= S_PARITY;
                            end else begin
                                tx_pin   <= 1'b1;
                                tx_state <= S_STOP;
                            end
                        end else begin
                            // next bit goes out while the register shifts it down to [0]
                            tx_bit   <= tx_bit + 1'b1;
                            tx_pin   <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt   <= '0;
                        tx_pin   <= 1'b1;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt <= '0;
                        if (tx_bit == LAST_STOP) begin
                            tx_bit   <= '0;
                            tx_busy  <= 1'b0;
                            tx_state <= S_IDLE;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    // rx_s1/rx_s2 synchronise the pin; rx_s3 is the previous synchronised value for edge detection.
    logic rx_s1, rx_s2, rx_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_pin;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    state_t               rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_brk;     // stop bit was low: hold until the line returns high

    logic stop_sample, par_bad, push, pop, do_push, fifo_full;

    assign stop_sample = (rx_state == S_STOP) && !rx_brk && (rx_cnt == DIV_M1);
    assign par_bad     = (PARITY != 0) &&
                         (rx_par_bit != ((PARITY == 1) ? ~^rx_shift : ^rx_shift));
    assign push        = stop_sample && rx_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state      <= S_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par_bit    <= 1'b0;
            rx_brk        <= 1'b0;
            rx_busy       <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_cnt   <= '0;
                        rx_busy  <= 1'b1;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        if (rx_s2) begin
                            rx_busy  <= 1'b0;     // false start: glitch shorter than half a bit
                            rx_state <= S_IDLE;
                        end else begin
                            rx_state <= S_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == DIV_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == LAST_BIT) begin
                            rx_bit   <= '0;
                            rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == DIV_M1) begin
                        rx_cnt     <= '0;
                        rx_par_bit <= rx_s2;
                        rx_state   <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // only the first stop bit is checked; a second one is treated as idle line
                    if (rx_brk) begin
                        if (rx_s2) begin
                            rx_brk   <= 1'b0;
                            rx_busy  <= 1'b0;
                            rx_state <= S_IDLE;
                        end
                    end else if (rx_cnt == DIV_M1) begin
                        rx_cnt        <= '0;
                        rx_frame_err  <= !rx_s2;
                        rx_parity_err <= par_bad;
                        if (rx_s2) begin
                            rx_busy  <= 1'b0;
                            rx_state <= S_IDLE;
                        end else begin
                            rx_brk <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO (first-word fall-through) ----------------
    logic [DATA_BITS-1:0] mem [RX_FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;

    assign rx_valid  = (rx_count != '0);
    assign fifo_full = (rx_count == FULL_CNT);
    assign pop       = rx_rd && rx_valid;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push   = push && (!fifo_full || pop);
    assign rx_byte   = rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= rx_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_count   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
            if (err_clear) begin
                rx_overrun <= 1'b0;
            end else if (push && fifo_full && !pop) begin
                rx_overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core: instance A is 8N1 with a 4-entry FIFO (optionally looped back),
// instance B is 7 data bits, even parity, 2 stop bits. Both run at DIV = 10.
module tb_uart_fifo_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A: 8N1, depth 4
    logic       a_loop, a_drv, a_rx, a_tx, a_tx_start, a_tx_busy, a_rx_valid, a_rx_rd;
    logic       a_rx_busy, a_fe, a_pe, a_ovr, a_clr;
    logic [7:0] a_tx_byte, a_rx_byte;
    logic [2:0] a_rx_count;
    assign a_rx = a_loop ? a_tx : a_drv;

    // instance B: 7E2, depth 16
    logic       b_rx, b_tx, b_tx_start, b_tx_busy, b_rx_valid, b_rx_rd;
    logic       b_rx_busy, b_fe, b_pe, b_ovr, b_clr;
    logic [6:0] b_tx_byte, b_rx_byte;
    logic [4:0] b_rx_count;

    uart_fifo_core #(.CLOCK(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .rx_pin(a_rx), .tx_pin(a_tx),
        .tx_byte(a_tx_byte), .tx_start(a_tx_start), .tx_busy(a_tx_busy),
        .rx_byte(a_rx_byte), .rx_valid(a_rx_valid), .rx_rd(a_rx_rd), .rx_count(a_rx_count),
        .rx_busy(a_rx_busy), .rx_frame_err(a_fe), .rx_parity_err(a_pe),
        .rx_overrun(a_ovr), .err_clear(a_clr));

    uart_fifo_core #(.CLOCK(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                     .STOP_BITS(2), .RX_FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst(rst), .rx_pin(b_rx), .tx_pin(b_tx),
        .tx_byte(b_tx_byte), .tx_start(b_tx_start), .tx_busy(b_tx_busy),
        .rx_byte(b_rx_byte), .rx_valid(b_rx_valid), .rx_rd(b_rx_rd), .rx_count(b_rx_count),
        .rx_busy(b_rx_busy), .rx_frame_err(b_fe), .rx_parity_err(b_pe),
        .rx_overrun(b_ovr), .err_clear(b_clr));

    // running pulse counters; checks compare before/after snapshots
    int a_fe_n = 0, a_pe_n = 0, b_fe_n = 0, b_pe_n = 0;
    always @(negedge clk) begin
        if (a_fe) a_fe_n++;
        if (a_pe) a_pe_n++;
        if (b_fe) b_fe_n++;
        if (b_pe) b_pe_n++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // frame bit vectors, bit 0 first on the line
    function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
        frame8 = {6'h3f, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame7e(input logic [6:0] d, input logic flip);
        frame7e = {5'h1f, 2'b11, (^d) ^ flip, d, 1'b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // drive nbits bit-times of 10 clocks onto A (sel 0) or B (sel 1); pulse a_rx_rd at clock rd_at
    task automatic send(input int sel, input logic [15:0] bits, input int nbits, input int rd_at);
        for (int i = 0; i < nbits * 10; i++) begin
            @(negedge clk);
            if (sel == 0) a_drv = bits[i / 10];
            else          b_rx  = bits[i / 10];
            a_rx_rd = (i == rd_at);
        end
        @(negedge clk);
        a_drv   = 1'b1;
        b_rx    = 1'b1;
        a_rx_rd = 1'b0;
    endtask

    task automatic pop(input int sel);
        @(negedge clk);
        if (sel == 0) a_rx_rd = 1'b1;
        else          b_rx_rd = 1'b1;
        @(negedge clk);
        a_rx_rd = 1'b0;
        b_rx_rd = 1'b0;
    endtask

    task automatic start_tx(input int sel, input logic [7:0] d);
        @(negedge clk);
        if (sel == 0) begin a_tx_byte = d; a_tx_start = 1'b1; end
        else          begin b_tx_byte = d[6:0]; b_tx_start = 1'b1; end
        @(negedge clk);
        a_tx_start = 1'b0;
        b_tx_start = 1'b0;
    endtask

    logic cap_pin [0:139];
    int   cap_busy;
    int   cap_low;

    // record the tx line; on A a second tx_start (data 0xFF) is attempted at clock 30
    task automatic capture(input int sel, input int n);
        cap_busy = 0;
        cap_low  = 0;
        for (int i = 0; i < n; i++) begin
            cap_pin[i] = (sel == 0) ? a_tx : b_tx;
            cap_busy  += (sel == 0) ? int'(a_tx_busy) : int'(b_tx_busy);
            cap_low   += (cap_pin[i] == 1'b0) ? 1 : 0;
            if (sel == 0) begin
                a_tx_start = (i == 30);
                if (i == 30) a_tx_byte = 8'hFF;
            end
            @(negedge clk);
        end
        a_tx_start = 1'b0;
    endtask

    function automatic logic [31:0] centre_bits(input int nb);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < nb; k++) v[k] = cap_pin[k * 10 + 5];
        return v;
    endfunction

    int fe0, pe0;
    int seen_busy;

    initial begin
        rst = 1'b1;
        a_loop = 1'b0; a_drv = 1'b1; a_tx_start = 1'b0; a_tx_byte = '0; a_rx_rd = 1'b0; a_clr = 1'b0;
        b_rx = 1'b1; b_tx_start = 1'b0; b_tx_byte = '0; b_rx_rd = 1'b0; b_clr = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_tx_pin", 32'(a_tx), 1);
        chk("rst_tx_busy", 32'(a_tx_busy), 0);
        chk("rst_rx_busy", 32'(a_rx_busy), 0);
        chk("rst_rx_valid", 32'(a_rx_valid), 0);
        chk("rst_rx_count", 32'(a_rx_count), 0);
        chk("rst_rx_byte", 32'(a_rx_byte), 0);
        chk("rst_errs", 32'({a_fe, a_pe, a_ovr}), 0);
        chk("rst_b_count", 32'(b_rx_count), 0);

        // 8N1 loopback of 0xA5, with an ignored tx_start mid-frame
        a_loop = 1'b1;
        fe0 = a_fe_n; pe0 = a_pe_n;
        start_tx(0, 8'hA5);
        capture(0, 120);
        chk("a5_busy_clks", 32'(cap_busy), 100);
        chk("a5_low_clks", 32'(cap_low), 50);
        chk("a5_line_bits", centre_bits(10), 32'h34A);
        chk("a5_rx_valid", 32'(a_rx_valid), 1);
        chk("a5_rx_byte", 32'(a_rx_byte), 32'hA5);
        chk("a5_rx_count", 32'(a_rx_count), 1);
        chk("a5_no_err", 32'((a_fe_n - fe0) + (a_pe_n - pe0)), 0);
        pop(0);
        chk("a5_pop_count", 32'(a_rx_count), 0);
        chk("a5_pop_valid", 32'(a_rx_valid), 0);
        a_loop = 1'b0;

        // 7E2 transmit: 0x54 has three ones, so even parity bit is 1; frame is 11 bits
        start_tx(1, 8'h54);
        capture(1, 130);
        chk("b_tx_busy_clks", 32'(cap_busy), 110);
        chk("b_tx_line_bits", centre_bits(11), 32'h7A8);

        // 7E2 receive: clean 0x55, then 0x55 with flipped parity (still queued)
        fe0 = b_fe_n; pe0 = b_pe_n;
        send(1, frame7e(7'h55, 1'b0), 11, -1);
        idle(10);
        chk("b_clean_count", 32'(b_rx_count), 1);
        chk("b_clean_byte", 32'(b_rx_byte), 32'h55);
        chk("b_clean_pe", 32'(b_pe_n - pe0), 0);
        send(1, frame7e(7'h55, 1'b1), 11, -1);
        idle(10);
        chk("b_bad_pe_pulses", 32'(b_pe_n - pe0), 1);
        chk("b_bad_fe_pulses", 32'(b_fe_n - fe0), 0);
        chk("b_bad_count", 32'(b_rx_count), 2);
        pop(1);
        chk("b_second_byte", 32'(b_rx_byte), 32'h55);
        pop(1);
        chk("b_drained", 32'(b_rx_count), 0);

        // framing error on 0x3C, then clean 0x12
        fe0 = a_fe_n; pe0 = a_pe_n;
        send(0, frame8(8'h3C, 1'b0), 10, -1);
        idle(10);
        chk("fe_pulses", 32'(a_fe_n - fe0), 1);
        chk("fe_pe_pulses", 32'(a_pe_n - pe0), 0);
        chk("fe_count", 32'(a_rx_count), 0);
        send(0, frame8(8'h12, 1'b1), 10, -1);
        idle(10);
        chk("after_fe_byte", 32'(a_rx_byte), 32'h12);
        chk("after_fe_count", 32'(a_rx_count), 1);
        chk("after_fe_pulses", 32'(a_fe_n - fe0), 1);
        pop(0);

        // overrun: five bytes into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            send(0, frame8(8'(i), 1'b1), 10, -1);
            idle(5);
        end
        chk("ovr_count", 32'(a_rx_count), 4);
        chk("ovr_flag", 32'(a_ovr), 1);
        chk("ovr_head", 32'(a_rx_byte), 32'h01);
        @(negedge clk); a_clr = 1'b1;
        @(negedge clk); a_clr = 1'b0;
        chk("ovr_cleared", 32'(a_ovr), 0);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_drain_head", 32'(a_rx_byte), 32'(i));
            pop(0);
        end
        chk("ovr_drained", 32'(a_rx_count), 0);

        // full FIFO with a pop on the push cycle (stop sample lands 98 clocks into the frame)
        for (int i = 0; i < 4; i++) begin
            send(0, frame8(8'h11 + 8'(i), 1'b1), 10, -1);
            idle(5);
        end
        chk("full_count", 32'(a_rx_count), 4);
        send(0, frame8(8'h15, 1'b1), 10, 97);
        idle(5);
        chk("push_pop_ovr", 32'(a_ovr), 0);
        chk("push_pop_count", 32'(a_rx_count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("push_pop_head", 32'(a_rx_byte), 32'h12 + 32'(i));
            pop(0);
        end

        // 3-clock glitch on idle line
        fe0 = a_fe_n; pe0 = a_pe_n;
        seen_busy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_rx_busy) seen_busy = 1;
            if (i == 8) chk("glitch_busy_cleared", 32'(a_rx_busy), 0);
            if (i == 0) a_drv = 1'b0;
            if (i == 3) a_drv = 1'b1;
        end
        chk("glitch_busy_seen", 32'(seen_busy), 1);
        chk("glitch_count", 32'(a_rx_count), 0);
        chk("glitch_errs", 32'((a_fe_n - fe0) + (a_pe_n - pe0)), 0);

        // reset mid-frame in both directions with a byte already queued
        send(0, frame8(8'h77, 1'b1), 10, -1);
        idle(5);
        chk("pre_rst_count", 32'(a_rx_count), 1);
        a_loop = 1'b1;
        start_tx(0, 8'h81);
        idle(50);
        chk("pre_rst_busy", 32'({a_tx_busy, a_rx_busy}), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_tx_pin", 32'(a_tx), 1);
        chk("mid_rst_tx_busy", 32'(a_tx_busy), 0);
        chk("mid_rst_rx_busy", 32'(a_rx_busy), 0);
        chk("mid_rst_count", 32'(a_rx_count), 0);
        fe0 = a_fe_n;
        start_tx(0, 8'h3C);
        idle(120);
        chk("post_rst_byte", 32'(a_rx_byte), 32'h3C);
        chk("post_rst_count", 32'(a_rx_count), 1);
        chk("post_rst_fe", 32'(a_fe_n - fe0), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
